// File: rtl/nisc_fetch.sv
// NISC instruction fetch: drives the synchronous program ROM, tracks one
// in-flight read and buffers returned words in a 2-entry FIFO for the datapath.
module nisc_fetch #(
    parameter int Psize = 6,
    parameter int Isize = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [Psize-1:0] pcAddr,
    output logic             hold,
    output logic [Psize-1:0] romAddr,
    output logic             romEn,
    input  logic [Isize-1:0] romData,
    input  logic             flush,
    output logic [Isize-1:0] instr,
    output logic [Psize-1:0] instrAddr,
    output logic             instrValid,
    input  logic             instrReady
);

    logic [1:0]       count_q, count_d;
    logic             rptr_q, rptr_d;
    logic             wptr_q, wptr_d;
    logic             req_valid_q, req_valid_d;
    logic [Psize-1:0] req_addr_q, req_addr_d;

    logic [Isize-1:0] data_q [2];
    logic [Psize-1:0] addr_q [2];
    logic [Isize-1:0] last_instr_q;
    logic [Psize-1:0] last_addr_q;

    logic             empty;
    logic             push;
    logic             pop;
    logic [1:0]       credit;
    logic [Isize-1:0] head_instr;
    logic [Psize-1:0] head_addr;

    assign empty      = (count_q == 2'd0);
    assign instrValid = !Reset && !empty;
    assign pop        = instrValid && instrReady;
    assign push       = req_valid_q;

    // Slots the FIFO must still absorb: queued + in flight - leaving now
    assign credit = count_q + {1'b0, req_valid_q} - {1'b0, pop};
    assign hold   = Reset || (!flush && (credit >= 2'd2));
    assign romEn  = !hold;
    assign romAddr = pcAddr;

    assign head_instr = data_q[rptr_q];
    assign head_addr  = addr_q[rptr_q];

    always_comb begin
        instr     = head_instr;
        instrAddr = head_addr;
        if (Reset) begin
            instr     = '0;
            instrAddr = '0;
        end else if (empty) begin
            instr     = last_instr_q;
            instrAddr = last_addr_q;
        end
    end

    always_comb begin
        count_d     = count_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        req_valid_d = romEn;
        req_addr_d  = romEn ? pcAddr : req_addr_q;
        if (flush) begin
            count_d     = 2'd0;
            rptr_d      = 1'b0;
            wptr_d      = 1'b0;
            req_valid_d = 1'b0;
        end else begin
            if (push) wptr_d = !wptr_q;
            if (pop)  rptr_d = !rptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            count_q      <= 2'd0;
            rptr_q       <= 1'b0;
            wptr_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            last_instr_q <= '0;
            last_addr_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            if (push && !flush) begin
                data_q[wptr_q] <= romData;
                addr_q[wptr_q] <= req_addr_q;
            end
            // Remember the presented head so an empty queue keeps showing it
            if (!empty) begin
                last_instr_q <= head_instr;
                last_addr_q  <= head_addr;
            end
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (Reset || flush)
        !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_nisc_fetch.sv
// Bench for nisc_fetch: directed cycle table plus a randomized run
// scored against an in-order transaction model of issued fetches.
module tb_nisc_fetch;

    logic        clk = 1'b0;
    logic        Reset;
    logic [5:0]  pcAddr;
    logic        hold;
    logic [5:0]  romAddr;
    logic        romEn;
    logic [15:0] romData;
    logic        flush;
    logic [15:0] instr;
    logic [5:0]  instrAddr;
    logic        instrValid;
    logic        instrReady;

    logic [15:0] rom [64];
    logic [5:0]  pc_tgt;
    int          n_total = 0;
    int          n_pass  = 0;

    nisc_fetch #(.Psize(6), .Isize(16)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .pcAddr     (pcAddr),
        .hold       (hold),
        .romAddr    (romAddr),
        .romEn      (romEn),
        .romData    (romData),
        .flush      (flush),
        .instr      (instr),
        .instrAddr  (instrAddr),
        .instrValid (instrValid),
        .instrReady (instrReady)
    );

    always #5 clk = ~clk;

    // Program counter and synchronous ROM surrounding the fetch stage
    always @(posedge clk) begin
        if (Reset)      pcAddr <= 6'd0;
        else if (flush) pcAddr <= pc_tgt;
        else if (!hold) pcAddr <= pcAddr + 6'd1;
    end

    always @(posedge clk) begin
        if (romEn) romData <= rom[romAddr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic        eh;
        logic        ck;
        logic [15:0] ei;
        logic [5:0]  ea;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic rst, input logic fl, input logic rdy,
                       input logic ev, input logic eh, input logic ck,
                       input logic [15:0] ei, input logic [5:0] ea);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rdy = rdy;
        v.ev = ev; v.eh = eh; v.ck = ck; v.ei = ei; v.ea = ea;
        tbl.push_back(v);
    endtask

    logic [5:0] q [$];
    logic [5:0] prev_addr;
    bit         wrap_seen;
    int         pops;

    initial begin
        Reset = 1'b1;
        flush = 1'b0;
        instrReady = 1'b0;
        pc_tgt = 6'h20;
        pcAddr = 6'd0;
        romData = 16'd0;
        for (int i = 0; i < 64; i++) rom[i] = 16'h1000 + 16'(i);

        // rst fl rdy | valid hold chk instr addr
        add(1, 0, 1, 0, 1, 1, 16'h0000, 6'h00);
        add(0, 0, 1, 0, 0, 0, 16'h0000, 6'h00);
        add(0, 0, 1, 0, 0, 0, 16'h0000, 6'h00);
        add(0, 0, 1, 1, 0, 1, 16'h1000, 6'h00);
        add(0, 0, 1, 1, 0, 1, 16'h1001, 6'h01);
        add(0, 0, 1, 1, 0, 1, 16'h1002, 6'h02);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 1, 1, 1, 16'h1003, 6'h03);
        add(0, 0, 1, 1, 0, 1, 16'h1003, 6'h03);
        add(0, 0, 1, 1, 0, 1, 16'h1004, 6'h04);
        add(0, 0, 0, 1, 1, 1, 16'h1005, 6'h05);
        add(0, 1, 0, 1, 0, 1, 16'h1005, 6'h05);
        add(0, 0, 1, 0, 0, 0, 16'h0000, 6'h00);
        add(0, 0, 1, 0, 0, 0, 16'h0000, 6'h00);
        add(0, 0, 1, 1, 0, 1, 16'h1020, 6'h20);
        add(0, 0, 1, 1, 0, 1, 16'h1021, 6'h21);
        add(0, 0, 0, 1, 1, 1, 16'h1022, 6'h22);
        add(0, 0, 0, 1, 1, 1, 16'h1022, 6'h22);
        add(1, 1, 0, 0, 1, 1, 16'h0000, 6'h00);
        add(0, 0, 1, 0, 0, 1, 16'h0000, 6'h00);
        add(0, 0, 1, 0, 0, 1, 16'h0000, 6'h00);
        add(0, 0, 1, 1, 0, 1, 16'h1000, 6'h00);
        add(0, 0, 1, 1, 0, 1, 16'h1001, 6'h01);

        repeat (2) @(posedge clk);
        foreach (tbl[k]) begin
            @(posedge clk); #1;
            Reset      = tbl[k].rst;
            flush      = tbl[k].fl;
            instrReady = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("s%0d_valid", k), 32'(instrValid), 32'(tbl[k].ev));
            chk($sformatf("s%0d_hold", k), 32'(hold), 32'(tbl[k].eh));
            chk($sformatf("s%0d_romEn", k), 32'(romEn), 32'(!tbl[k].eh));
            chk($sformatf("s%0d_romAddr", k), 32'(romAddr), 32'(pcAddr));
            if (tbl[k].ck) begin
                chk($sformatf("s%0d_instr", k), 32'(instr), 32'(tbl[k].ei));
                chk($sformatf("s%0d_addr", k), 32'(instrAddr), 32'(tbl[k].ea));
            end
        end

        // Randomized run: every issued, non-flushed fetch emerges in order
        @(posedge clk); #1;
        Reset = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
        @(posedge clk); #1;
        Reset = 1'b0;
        wrap_seen = 1'b0;
        prev_addr = 6'd0;
        pops = 0;
        for (int c = 0; c < 1000; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            instrReady = 1'($urandom_range(0, 1));
            flush      = (c >= 500) && ($urandom_range(0, 63) == 0);
            pc_tgt     = 6'($urandom);
            @(negedge clk);
            if (instrValid) begin
                if (q.size() == 0) begin
                    chk("rnd_valid_no_fetch", 32'(instrValid), 32'd0);
                end else begin
                    chk("rnd_addr", 32'(instrAddr), 32'(q[0]));
                    chk("rnd_instr", 32'(instr), 32'(rom[q[0]]));
                    if (instrReady) begin
                        if (prev_addr == 6'd63 && q[0] == 6'd0)
                            wrap_seen = 1'b1;
                        prev_addr = q[0];
                        void'(q.pop_front());
                        pops++;
                    end
                end
            end
            if (flush) q.delete();
            else if (romEn) q.push_back(romAddr);
            if (q.size() > 3) chk("rnd_occupancy", 32'(q.size()), 32'd3);
        end
        chk("rnd_pc_wrap_seen", 32'(wrap_seen), 32'd1);
        chk("rnd_enough_words", 32'(pops >= 200), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
